// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with registered sync, blanking and frame pulses.
// All flags load from next-count values so they align with the counts they describe.
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_tick,
  output logic [15:0] frame_cnt
);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_A    = 11'(H_ACTIVE);
  localparam logic [10:0] V_A    = 11'(V_ACTIVE);
  localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d, vblnk_q, vblnk_d;
  logic        tick_q, tick_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        h_wrap, v_wrap;
  always_comb begin
    h_wrap   = hcount_q == H_LAST;
    v_wrap   = vcount_q == V_LAST;
    hcount_d = h_wrap ? '0 : hcount_q + 11'd1;
    vcount_d = h_wrap ? (v_wrap ? '0 : vcount_q + 11'd1) : vcount_q;
    hblnk_d  = hcount_d >= H_A;
    vblnk_d  = vcount_d >= V_A;
    hsync_d  = (hcount_d >= H_SS && hcount_d < H_SE) ? SYNC_POL : !SYNC_POL;
    vsync_d  = (vcount_d >= V_SS && vcount_d < V_SE) ? SYNC_POL : !SYNC_POL;
    tick_d   = h_wrap && v_wrap;
    fcnt_d   = fcnt_q + 16'(tick_d);
  end
  // Reset leaves (0,0) without a tick; only a real wrap from the last pixel ticks.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= !SYNC_POL;
      vsync_q  <= !SYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      tick_q   <= 1'b0;
      fcnt_q   <= '0;
    end else if (en) begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      tick_q   <= tick_d;
      fcnt_q   <= fcnt_d;
    end else begin
      tick_q   <= 1'b0;
    end
  end
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_q;
  assign frame_tick = tick_q;
  assign frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboarded check of vga_timing on a shrunken raster, both sync
// polarities, plus a one-pixel raster that ticks every cycle to reach the frame_cnt wrap.
module tb_vga_timing;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  typedef struct {
    logic [10:0] h, v;
    logic        hs, vs, hb, vb, tk;
    logic [15:0] cnt;
  } exp_t;
  logic        pclk = 1'b0, rst = 1'b0, en = 1'b0, rst_w = 1'b0;
  logic [10:0] hcount, vcount, hcount0, vcount0, hcount_w, vcount_w;
  logic        hsync, vsync, hblnk, vblnk, tick;
  logic        hsync0, vsync0, hblnk0, vblnk0, tick0;
  logic        hsync_w, vsync_w, hblnk_w, vblnk_w, tick_w;
  logic [15:0] fcnt, fcnt0, fcnt_w;
  int          n_chk = 0, n_err = 0;
  int          mh = 0, mv = 0;
  logic        mtk = 1'b0;
  logic [15:0] mcnt = '0;
  exp_t        sb[$];
  always #5 pclk = ~pclk;
  vga_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b1)) dut (
    .pclk(pclk), .rst(rst), .en(en), .hcount_out(hcount), .vcount_out(vcount),
    .hsync_out(hsync), .vsync_out(vsync), .hblnk_out(hblnk), .vblnk_out(vblnk),
    .frame_tick(tick), .frame_cnt(fcnt));
  vga_timing #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
               .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)) dut_n (
    .pclk(pclk), .rst(rst), .en(en), .hcount_out(hcount0), .vcount_out(vcount0),
    .hsync_out(hsync0), .vsync_out(vsync0), .hblnk_out(hblnk0), .vblnk_out(vblnk0),
    .frame_tick(tick0), .frame_cnt(fcnt0));
  vga_timing #(.H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
               .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0), .SYNC_POL(1'b1)) dut_w (
    .pclk(pclk), .rst(rst_w), .en(1'b1), .hcount_out(hcount_w), .vcount_out(vcount_w),
    .hsync_out(hsync_w), .vsync_out(vsync_w), .hblnk_out(hblnk_w), .vblnk_out(vblnk_w),
    .frame_tick(tick_w), .frame_cnt(fcnt_w));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t h=%0d v=%0d", tag, got, exp, $time, mh, mv);
    end
  endtask
  function automatic exp_t exp_now();
    exp_t e;
    e.h   = 11'(mh);
    e.v   = 11'(mv);
    e.hb  = mh >= HA;
    e.vb  = mv >= VA;
    e.hs  = mh >= HA + HF && mh <= HA + HF + HS - 1;
    e.vs  = mv >= VA + VF && mv <= VA + VF + VS - 1;
    e.tk  = mtk;
    e.cnt = mcnt;
    return e;
  endfunction
  task automatic compare(input exp_t e);
    check("hcount", hcount, e.h);
    check("vcount", vcount, e.v);
    check("hblnk", hblnk, e.hb);
    check("vblnk", vblnk, e.vb);
    check("hsync", hsync, e.hs);
    check("vsync", vsync, e.vs);
    check("frame_tick", tick, e.tk);
    check("frame_cnt", fcnt, e.cnt);
    check("hsync_n", hsync0, !e.hs);
    check("vsync_n", vsync0, !e.vs);
  endtask
  task automatic step(input logic e);
    exp_t got_e;
    en = e;
    mtk = 1'b0;
    if (e) begin
      mtk = mh == HT - 1 && mv == VT - 1;
      if (mh == HT - 1) begin
        mh = 0;
        mv = mv == VT - 1 ? 0 : mv + 1;
      end else mh++;
      mcnt = mcnt + 16'(mtk);
    end
    sb.push_back(exp_now());
    @(posedge pclk);
    #1;
    check("sb_depth", sb.size(), 1);
    got_e = sb.pop_front();
    compare(got_e);
  endtask
  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    mh = 0; mv = 0; mtk = 1'b0; mcnt = '0;
    compare(exp_now());
    repeat (3) @(posedge pclk);
    #1;
    compare(exp_now());
    rst = 1'b1;
  endtask
  task automatic run_to(input int h, input int v, input int lim);
    int n = 0;
    while (!(mh == h && mv == v) && n < lim) begin
      step(1'b1);
      n++;
    end
    check("run_to_reached", n < lim, 1);
  endtask
  initial begin
    @(posedge pclk);
    #1;
    compare(exp_now());
    reset_pulse();
    step(1'b1);
    check("first_h_is_1", hcount, 1);
    check("no_reset_tick", tick, 0);
    repeat (299) step(1'b1);
    check("cnt_after_300", fcnt, 2);
    run_to(HT - 1, VT - 1, 500);
    repeat (10) step(1'b0);
    step(1'b1);
    check("resume_tick", tick, 1);
    check("resume_h", hcount, 0);
    run_to(5, 2, 500);
    check("cnt_before_rst", fcnt, 3);
    @(posedge pclk);
    #1;
    reset_pulse();
    check("cnt_after_rst", fcnt, 0);
    step(1'b1);
    check("after_abort_h", hcount, 1);
    repeat (300) step(1'($urandom_range(0, 1)));
    repeat (140) step(1'b1);
    rst_w = 1'b1;
    repeat (65535) @(posedge pclk);
    #1;
    check("wrap_cnt_ffff", fcnt_w, 16'hffff);
    @(posedge pclk);
    #1;
    check("wrap_cnt_0", fcnt_w, 0);
    check("wrap_tick", tick_w, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_FP, 40, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 128, hsync pulse width in pixels.
REQ-004 Parameter H_BP, 88, horizontal back porch in pixels; line total H_TOT = sum of the four = 1056.
REQ-005 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-006 Parameter V_FP, 1, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 4, vsync pulse width in lines.
REQ-008 Parameter V_BP, 23, vertical back porch in lines; frame total V_TOT = sum of the four = 628.
REQ-009 Parameter SYNC_POL, 1, sync active level: 1 = active-high, 0 = active-low.
REQ-010 One clock, pclk; reset rst is asynchronous and active-low.
REQ-011 pclk  in  1  pixel clock; all state updates on its rising edge.
REQ-012 rst  in  1  asynchronous active-low reset.
REQ-013 en  in  1  pixel-advance enable; low freezes all state.
REQ-014 hcount_out  out  11  current pixel column, 0..H_TOT-1.
REQ-015 vcount_out  out  11  current line, 0..V_TOT-1.
REQ-016 hsync_out  out  1  horizontal sync at SYNC_POL level during pulse.
REQ-017 vsync_out  out  1  vertical sync at SYNC_POL level during pulse.
REQ-018 hblnk_out  out  1  high outside horizontal active region.
REQ-019 vblnk_out  out  1  high outside vertical active region.
REQ-020 frame_tick  out  1  one-cycle pulse at start of each new frame.
REQ-021 frame_cnt  out  16  completed-frame counter, wraps modulo 2^16.

Function
REQ-022 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.
REQ-023 With en=1, hcount_out SHALL increment by 1 per cycle, wrapping H_TOT-1 -> 0.
REQ-024 vcount_out SHALL increment by 1 only in the cycle hcount_out wraps, wrapping V_TOT-1 -> 0; otherwise hold.
REQ-025 Each cycle, hblnk_out SHALL equal (hcount_out >= H_ACTIVE) and vblnk_out SHALL equal (vcount_out >= V_ACTIVE), i.e. aligned to the same-cycle counts with zero relative latency.
REQ-026 hsync_out SHALL be at the active level iff H_ACTIVE+H_FP <= hcount_out <= H_ACTIVE+H_FP+H_SYNC-1 (840..967 at defaults), else the inactive level.
REQ-027 vsync_out SHALL be at the active level iff V_ACTIVE+V_FP <= vcount_out <= V_ACTIVE+V_FP+V_SYNC-1 (601..604 at defaults), independent of hcount_out.
REQ-028 To meet REQ-025..027, flag registers SHALL be loaded from the next-count values, not delayed from the current counts.
REQ-029 frame_tick SHALL be 1 in exactly the cycle where hcount_out=0 and vcount_out=0 following a wrap from (H_TOT-1, V_TOT-1); 0 otherwise.
REQ-030 frame_cnt SHALL increment in the same cycle frame_tick asserts; 0xFFFF -> 0x0000.
REQ-031 With en=0, all outputs SHALL hold their values; frame_tick SHALL be 0; resuming continues from the held position with no skipped or repeated count.
REQ-032 Counter widths: 11 bits suffice for H_TOT, V_TOT <= 2048; parameter values exceeding this are unsupported.

Reset
REQ-033 While rst=0: hcount_out=0, vcount_out=0, hblnk_out=0, vblnk_out=0, hsync_out=vsync_out=!SYNC_POL, frame_tick=0, frame_cnt=0, asynchronously.
REQ-034 First cycle after rst rises with en=1: hcount_out=1; no frame_tick is emitted for the reset-induced (0,0).
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately; frame_cnt does not count it.

Verification
REQ-036 Release reset, en=1, run 1056 cycles -> hcount 0..1055 then 0, vcount 0->1 at wrap, hblnk high for 800..1055, hsync high for 840..967 exactly.
REQ-037 Run one full frame (663168 cycles) -> vblnk high for lines 600..627, vsync high lines 601..604, one frame_tick at (0,0), frame_cnt=1.
REQ-038 Toggle en low for 10 cycles at hcount=1055, vcount=627 -> outputs frozen, no tick; on en=1 next cycle shows (0,0), frame_tick=1.
REQ-039 Assert rst at hcount=500, vcount=300, frame_cnt=3 -> immediate all-zero outputs, syncs inactive; frame_cnt=0 after release.
REQ-040 SYNC_POL=0 build -> hsync_out low only for 840..967, vsync_out low only for lines 601..604, high during reset.
REQ-041 Force frame_cnt to 0xFFFF via 65535 frames (or shortened parameters H_TOT=8, V_TOT=4) -> next tick wraps frame_cnt to 0.
